// File: rtl/uart_pkg.sv
// Shared definitions for the UART command responder: command/reply codes
// and the responder FSM state type.
package uart_pkg;

    // Host command bytes
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    // Reply bytes
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_TX_SEND,
        ST_TX_WAIT_BUSY,
        ST_TX_WAIT_DONE
    } uart_cmd_state_t;

    // True when the full 8-bit address selects an existing register
    function automatic logic addr_legal(input logic [7:0] addr, input int reg_num);
        return ({1'b0, addr} < 9'(reg_num));
    endfunction

endpackage

// File: rtl/uart_cmd_regfile.sv
// REG_NUM x 8-bit register bank with one write port, one combinational
// read port and a flat view of all registers.
module uart_cmd_regfile #(
    parameter int REG_NUM = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [7:0]           waddr,
    input  logic [7:0]           wdata,
    input  logic [7:0]           raddr,
    output logic [7:0]           rdata,
    output logic [8*REG_NUM-1:0] regs
);

    logic [7:0] mem_q [REG_NUM];
    logic [7:0] mem_d [REG_NUM];

    // Next register contents: only the addressed entry changes on a write;
    // addresses beyond the bank match no entry and are ignored.
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            mem_d[i] = mem_q[i];
            if (we && (waddr == 8'(i))) begin
                mem_d[i] = wdata;
            end
        end
    end

    // Register storage, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Combinational read; an unmapped address reads as zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (raddr == 8'(i)) begin
                rdata = mem_q[i];
            end
        end
    end

    for (genvar g = 0; g < REG_NUM; g++) begin : g_flat
        assign regs[8*g +: 8] = mem_q[g];
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-level command responder: decodes write (0x57,addr,data) and read
// (0x52,addr) commands from the UART receiver, executes them on a register
// bank and answers each executed command through the transmitter.
//
// Transmit handshake: tx_data_valid is a one-cycle request issued only while
// tx_busy=0. The transmitter accepts it by raising tx_busy and signals that
// the byte has left by lowering tx_busy again. tx_data is stable from the
// request until the reply completes.
module uart_cmd_responder
    import uart_pkg::*;
#(
    parameter int REG_NUM       = 16,
    parameter int TIMEOUT_TICKS = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_data_valid,
    input  logic [7:0]           rx_data,
    input  logic                 rx_error,
    input  logic                 sck_rising_edge,
    input  logic                 tx_busy,
    output logic                 tx_data_valid,
    output logic [7:0]           tx_data,
    output logic [8*REG_NUM-1:0] regs,
    output logic                 cmd_done,
    output logic                 frame_abort
);

    localparam int            TW      = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_TICKS);

    uart_cmd_state_t state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      addr_q, addr_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            done_q, done_d;
    logic            abort_q, abort_d;

    logic            rf_we;
    logic [7:0]      rf_rdata;
    logic            reply_load;
    logic [7:0]      reply_val;

    uart_cmd_regfile #(.REG_NUM(REG_NUM)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .waddr (addr_q),
        .wdata (rx_data),
        .raddr (rx_data),
        .rdata (rf_rdata),
        .regs  (regs)
    );

    // Command decode, timeout supervision and reply handshake
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        rf_we      = 1'b0;
        reply_load = 1'b0;
        reply_val  = RSP_NAK;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (rx_data_valid) begin
                    cmd_d = rx_data;
                    if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
                        state_d = ST_GET_ADDR;
                    end else begin
                        reply_load = 1'b1;
                        reply_val  = RSP_NAK;
                    end
                end
            end

            ST_GET_ADDR, ST_GET_DATA: begin
                if (sck_rising_edge && (tmo_q != TMO_MAX)) begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (rx_error) begin
                    // A framing error discards any byte strobed with it
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                end else if (rx_data_valid) begin
                    tmo_d = '0;
                    if (state_q == ST_GET_ADDR) begin
                        addr_d = rx_data;
                        if (cmd_q == CMD_WRITE) begin
                            state_d = ST_GET_DATA;
                        end else begin
                            reply_load = 1'b1;
                            reply_val  = addr_legal(rx_data, REG_NUM) ? rf_rdata : RSP_NAK;
                        end
                    end else begin
                        reply_load = 1'b1;
                        if (addr_legal(addr_q, REG_NUM)) begin
                            rf_we     = 1'b1;
                            reply_val = RSP_ACK;
                        end else begin
                            reply_val = RSP_NAK;
                        end
                    end
                end else if (tmo_q == TMO_MAX) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                end
            end

            ST_TX_SEND: begin
                if (!tx_busy) begin
                    tx_valid_d = 1'b1;
                    state_d    = ST_TX_WAIT_BUSY;
                end
            end

            ST_TX_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_TX_WAIT_DONE;
                end
            end

            ST_TX_WAIT_DONE: begin
                if (!tx_busy) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Entering TX_SEND with an idle transmitter issues the request on the
        // same edge, giving the one-cycle reply latency with a registered strobe.
        if (reply_load) begin
            tx_data_d = reply_val;
            if (!tx_busy) begin
                tx_valid_d = 1'b1;
                state_d    = ST_TX_WAIT_BUSY;
            end else begin
                state_d    = ST_TX_SEND;
            end
        end
    end

    // State, latches, timeout counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            tmo_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            tmo_q      <= tmo_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign tx_data_valid = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign cmd_done      = done_q;
    assign frame_abort   = abort_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: a transmitter model pops
// expected replies from a queue, a register model tracks the bank contents.
module tb_uart_cmd_responder;

    localparam int REG_NUM       = 16;
    localparam int TIMEOUT_TICKS = 20;
    localparam int RW            = 8 * REG_NUM;

    logic          clk;
    logic          rst_n;
    logic          rx_data_valid;
    logic [7:0]    rx_data;
    logic          rx_error;
    logic          sck_rising_edge;
    logic          tx_busy;
    logic          tx_data_valid;
    logic [7:0]    tx_data;
    logic [RW-1:0] regs;
    logic          cmd_done;
    logic          frame_abort;

    uart_cmd_responder #(
        .REG_NUM       (REG_NUM),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_data_valid   (rx_data_valid),
        .rx_data         (rx_data),
        .rx_error        (rx_error),
        .sck_rising_edge (sck_rising_edge),
        .tx_busy         (tx_busy),
        .tx_data_valid   (tx_data_valid),
        .tx_data         (tx_data),
        .regs            (regs),
        .cmd_done        (cmd_done),
        .frame_abort     (frame_abort)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] mdl [REG_NUM];
    int         n_cmp = 0;
    int         n_err = 0;
    string      cur_tag = "init";
    int         last_rx_cyc = 0;
    bit         lat_check = 1'b1;
    bit         hold_busy = 1'b0;
    int         tx_pulses = 0;
    int         done_cnt = 0;
    int         abort_cnt = 0;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] mdl_flat();
        logic [RW-1:0] f;
        for (int i = 0; i < REG_NUM; i++) f[8*i +: 8] = mdl[i];
        return f;
    endfunction

    // ---------------- transmitter model / monitor ----------------
    initial begin
        int busy_cnt;
        logic [7:0] e;
        busy_cnt = 0;
        tx_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_data_valid) begin
                tx_pulses++;
                if (exp_q.size() == 0) begin
                    check({cur_tag, "_unexpected_tx"}, RW'(tx_data_valid), '0);
                end else begin
                    e = exp_q.pop_front();
                    check({cur_tag, "_reply"}, RW'(tx_data), RW'(e));
                end
                if (lat_check) check({cur_tag, "_latency"}, RW'(cyc - last_rx_cyc), RW'(1));
                busy_cnt = 4;
            end
            if (cmd_done) done_cnt++;
            if (frame_abort) abort_cnt++;
            tx_busy = hold_busy || (busy_cnt != 0);
            if (busy_cnt != 0) busy_cnt--;
        end
    end

    // ---------------- driver tasks (called aligned to a negedge) ----------------
    task automatic send_byte(input logic [7:0] b, input logic err);
        rx_data       = b;
        rx_data_valid = 1'b1;
        rx_error      = err;
        last_rx_cyc   = cyc;
        @(negedge clk);
        rx_data_valid = 1'b0;
        rx_error      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
        check({tag, "_done"}, RW'(done_cnt - d0), RW'(1));
    endtask

    task automatic wait_abort(input string tag, input int a0);
        for (int i = 0; i < 100 && abort_cnt == a0; i++) @(negedge clk);
        check({tag, "_abort"}, RW'(abort_cnt - a0), RW'(1));
    endtask

    task automatic run_cmd(input string tag, input int n, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] rsp);
        int d0;
        cur_tag = tag;
        d0 = done_cnt;
        exp_q.push_back(rsp);
        send_byte(b0, 1'b0);
        if (n > 1) send_byte(b1, 1'b0);
        if (n > 2) send_byte(b2, 1'b0);
        wait_done(tag, d0);
        check({tag, "_drained"}, RW'(exp_q.size()), '0);
    endtask

    task automatic write_reg(input string tag, input logic [7:0] a, input logic [7:0] d);
        logic legal;
        legal = (int'(a) < REG_NUM);
        run_cmd(tag, 3, 8'h57, a, d, legal ? 8'h06 : 8'h15);
        if (legal) mdl[int'(a)] = d;
        check({tag, "_regs"}, regs, mdl_flat());
    endtask

    task automatic read_reg(input string tag, input logic [7:0] a);
        run_cmd(tag, 2, 8'h52, a, 8'h00, (int'(a) < REG_NUM) ? mdl[int'(a)] : 8'h15);
    endtask

    task automatic tick_sck(input int n);
        for (int i = 0; i < n; i++) begin
            sck_rising_edge = 1'b1;
            @(negedge clk);
            sck_rising_edge = 1'b0;
            @(negedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int a0, p0, d0;
        rst_n = 1'b0;
        rx_data_valid = 1'b0;
        rx_data = '0;
        rx_error = 1'b0;
        sck_rising_edge = 1'b0;
        for (int i = 0; i < REG_NUM; i++) mdl[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", RW'(tx_data_valid), '0);
        check("rst_tx_data", RW'(tx_data), '0);
        check("rst_cmd_done", RW'(cmd_done), '0);
        check("rst_abort", RW'(frame_abort), '0);
        check("rst_regs", regs, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // write then read back
        write_reg("wr3", 8'h03, 8'hA5);
        check("wr3_byte", RW'(regs[31:24]), RW'(8'hA5));
        read_reg("rd3", 8'h03);

        // random legal writes and reads
        for (int k = 0; k < 4; k++) begin
            logic [7:0] a, d;
            a = 8'($urandom_range(0, REG_NUM - 1));
            d = 8'($urandom_range(0, 255));
            write_reg("wr_rand", a, d);
            read_reg("rd_rand", a);
        end

        // illegal addresses, including the first one past the bank
        write_reg("wr_ill", 8'h10, 8'h55);
        read_reg("rd_ill", 8'hFF);
        read_reg("rd_last", 8'(REG_NUM - 1));

        // unknown command, then a read
        run_cmd("unknown", 1, 8'h41, 8'h00, 8'h00, 8'h15);
        read_reg("rd0", 8'h00);

        // timeout in GET_DATA: one tick short must not abort
        cur_tag = "tmo";
        a0 = abort_cnt;
        p0 = tx_pulses;
        send_byte(8'h57, 1'b0);
        send_byte(8'h01, 1'b0);
        tick_sck(TIMEOUT_TICKS - 1);
        repeat (3) @(negedge clk);
        check("tmo_early", RW'(abort_cnt - a0), '0);
        tick_sck(1);
        wait_abort("tmo", a0);
        check("tmo_no_tx", RW'(tx_pulses - p0), '0);
        check("tmo_regs", regs, mdl_flat());
        read_reg("tmo_rd1", 8'h01);

        // rx_error alone aborts, next byte starts a fresh frame
        cur_tag = "err";
        a0 = abort_cnt;
        send_byte(8'h57, 1'b0);
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        wait_abort("err", a0);
        run_cmd("err_restart", 1, 8'h06, 8'h00, 8'h00, 8'h15);

        // data byte strobed together with rx_error: abort wins, no write
        cur_tag = "err_data";
        a0 = abort_cnt;
        send_byte(8'h57, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h77, 1'b1);
        wait_abort("err_data", a0);
        check("err_data_regs", regs, mdl_flat());

        // transmitter held busy: no request until it frees up, bytes dropped
        lat_check = 1'b0;
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        cur_tag = "busy";
        p0 = tx_pulses;
        d0 = done_cnt;
        exp_q.push_back(mdl[3]);
        send_byte(8'h52, 1'b0);
        send_byte(8'h03, 1'b0);
        repeat (10) @(negedge clk);
        check("busy_held", RW'(tx_pulses - p0), '0);
        send_byte(8'h41, 1'b0);
        hold_busy = 1'b0;
        wait_done("busy", d0);
        repeat (10) @(negedge clk);
        check("busy_one_pulse", RW'(tx_pulses - p0), RW'(1));
        check("busy_drained", RW'(exp_q.size()), '0);

        // reset while waiting for the reply to finish
        cur_tag = "rst_mid";
        p0 = tx_pulses;
        exp_q.push_back(8'h06);
        send_byte(8'h57, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h3C, 1'b0);
        for (int i = 0; i < 50 && tx_pulses == p0; i++) @(negedge clk);
        check("rst_mid_sent", RW'(tx_pulses - p0), RW'(1));
        hold_busy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_valid", RW'(tx_data_valid), '0);
        check("rst_mid_tx_data", RW'(tx_data), '0);
        check("rst_mid_done", RW'(cmd_done), '0);
        check("rst_mid_abort", RW'(frame_abort), '0);
        check("rst_mid_regs", regs, '0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_busy = 1'b0;
        for (int i = 0; i < REG_NUM; i++) mdl[i] = '0;
        repeat (6) @(negedge clk);
        lat_check = 1'b1;
        read_reg("post_rst_rd5", 8'h05);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
